// File: rtl/mem_stage.sv
// Memory-access stage: drives a valid/ready data-memory handshake from EX/MEM controls,
// stalls upstream while an access is outstanding, aborts hung accesses and registers MEM/WB.
module mem_stage #(
    parameter int D_WIDTH = 32,
    parameter int RF_SIZE = 5,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [D_WIDTH-1:0] alu_out_mem,
    input  logic [D_WIDTH-1:0] rs2_val_mem,
    input  logic [RF_SIZE-1:0] rd_mem,
    input  logic               reg_write_mem,
    input  logic               mem_we_mem,
    input  logic               mem_re_mem,
    input  logic               mem_to_reg_mem,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [D_WIDTH-1:0] dmem_addr,
    output logic [D_WIDTH-1:0] dmem_wdata,
    input  logic               dmem_ready,
    input  logic [D_WIDTH-1:0] dmem_rdata,
    output logic               stall_mem,
    output logic [D_WIDTH-1:0] wb_data_wb,
    output logic [RF_SIZE-1:0] rd_wb,
    output logic               reg_write_wb,
    output logic               bus_err_wb
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    state_t             state_r;
    state_t             state_nxt_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_nxt_s;

    logic               access_s;
    logic               misaligned_s;
    logic               at_limit_s;
    logic               complete_s;
    logic               abort_s;
    logic               load_sel_s;

    // Access decode and handshake qualifiers
    always_comb begin
        access_s     = mem_we_mem | mem_re_mem;
        misaligned_s = access_s && (alu_out_mem[1:0] != 2'b00);
        at_limit_s   = (state_r == BUSY) && (cnt_r == TIMEOUT_C);
        dmem_req     = access_s && !misaligned_s;
        dmem_we      = mem_we_mem;
        dmem_addr    = alu_out_mem;
        dmem_wdata   = rs2_val_mem;
        complete_s   = dmem_req && dmem_ready;
        // The abort cycle still presents the request but releases the pipeline.
        abort_s      = dmem_req && !dmem_ready && at_limit_s;
        stall_mem    = dmem_req && !dmem_ready && !at_limit_s;
        load_sel_s   = mem_to_reg_mem && mem_re_mem && !mem_we_mem;
    end

    // Next-state and wait-counter logic
    always_comb begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = {CNT_W{1'b0}};
        case (state_r)
            IDLE: begin
                if (dmem_req && !dmem_ready) begin
                    state_nxt_s = BUSY;
                    cnt_nxt_s   = CNT_W'(1);
                end else begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end
            end
            BUSY: begin
                if (!dmem_req || complete_s || at_limit_s) begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end else begin
                    state_nxt_s = BUSY;
                    cnt_nxt_s   = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // FSM state and wait-counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // MEM/WB pipeline register: bubble while stalled, fault record on abort/misalign
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_data_wb   <= {D_WIDTH{1'b0}};
            rd_wb        <= {RF_SIZE{1'b0}};
            reg_write_wb <= 1'b0;
            bus_err_wb   <= 1'b0;
        end else if (stall_mem) begin
            wb_data_wb   <= {D_WIDTH{1'b0}};
            rd_wb        <= {RF_SIZE{1'b0}};
            reg_write_wb <= 1'b0;
            bus_err_wb   <= 1'b0;
        end else if (abort_s || misaligned_s) begin
            wb_data_wb   <= alu_out_mem;
            rd_wb        <= rd_mem;
            reg_write_wb <= 1'b0;
            bus_err_wb   <= 1'b1;
        end else begin
            wb_data_wb   <= load_sel_s ? dmem_rdata : alu_out_mem;
            rd_wb        <= rd_mem;
            reg_write_wb <= reg_write_mem;
            bus_err_wb   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed scoreboard bench for mem_stage with TIMEOUT=4: expected MEM/WB values are
// queued as each step is driven and popped after the clock edge that registers them.
module tb_mem_stage;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        rw;
        logic        err;
    } wb_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] alu_out_mem = 32'h0;
    logic [31:0] rs2_val_mem = 32'h0;
    logic [4:0]  rd_mem = 5'h0;
    logic        reg_write_mem = 1'b0;
    logic        mem_we_mem = 1'b0;
    logic        mem_re_mem = 1'b0;
    logic        mem_to_reg_mem = 1'b0;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ready = 1'b0;
    logic [31:0] dmem_rdata = 32'h0;
    logic        stall_mem;
    logic [31:0] wb_data_wb;
    logic [4:0]  rd_wb;
    logic        reg_write_wb;
    logic        bus_err_wb;

    int  n_checks = 0;
    int  n_pass   = 0;
    wb_t exp_q[$];

    mem_stage #(.D_WIDTH(32), .RF_SIZE(5), .TIMEOUT(4), .CNT_W(5)) dut (
        .clk(clk), .rst(rst),
        .alu_out_mem(alu_out_mem), .rs2_val_mem(rs2_val_mem), .rd_mem(rd_mem),
        .reg_write_mem(reg_write_mem), .mem_we_mem(mem_we_mem), .mem_re_mem(mem_re_mem),
        .mem_to_reg_mem(mem_to_reg_mem),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .stall_mem(stall_mem),
        .wb_data_wb(wb_data_wb), .rd_wb(rd_wb), .reg_write_wb(reg_write_wb), .bus_err_wb(bus_err_wb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // One clock of stimulus: check combinational bus outputs, queue the expected
    // MEM/WB contents, then pop and compare them after the edge.
    task automatic step(input string tag, input logic r,
                        input logic [31:0] alu, input logic [31:0] rs2, input logic [4:0] rd,
                        input logic rw, input logic we, input logic re, input logic m2r,
                        input logic rdy, input logic [31:0] rdata,
                        input logic e_req, input logic e_stall, input wb_t e_wb);
        wb_t got;
        rst = r; alu_out_mem = alu; rs2_val_mem = rs2; rd_mem = rd;
        reg_write_mem = rw; mem_we_mem = we; mem_re_mem = re; mem_to_reg_mem = m2r;
        dmem_ready = rdy; dmem_rdata = rdata;
        #1;
        chk({tag, ".req"},   32'(dmem_req),  32'(e_req));
        chk({tag, ".stall"}, 32'(stall_mem), 32'(e_stall));
        if (e_req) begin
            chk({tag, ".we"},    32'(dmem_we), 32'(we));
            chk({tag, ".addr"},  dmem_addr,    alu);
            chk({tag, ".wdata"}, dmem_wdata,   rs2);
        end
        exp_q.push_back(e_wb);
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        chk({tag, ".wb_data"}, wb_data_wb,          got.data);
        chk({tag, ".rd_wb"},   32'(rd_wb),          32'(got.rd));
        chk({tag, ".reg_wr"},  32'(reg_write_wb),   32'(got.rw));
        chk({tag, ".bus_err"}, 32'(bus_err_wb),     32'(got.err));
    endtask

    localparam wb_t BUBBLE = '{data: 32'h0, rd: 5'd0, rw: 1'b0, err: 1'b0};

    initial begin
        @(posedge clk); #1;
        //    tag      rst   alu           rs2           rd     rw    we    re    m2r   rdy   rdata         req   stall wb
        step("reset0", 1'b1, 32'h0,        32'h0,        5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, BUBBLE);
        step("reset1", 1'b1, 32'h0,        32'h0,        5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, BUBBLE);
        step("alu",    1'b0, 32'h1234,     32'h0,        5'd5,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, '{32'h1234, 5'd5, 1'b1, 1'b0});
        step("alurdy", 1'b0, 32'h55,       32'h0,        5'd3,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h99,       1'b0, 1'b0, '{32'h55, 5'd3, 1'b1, 1'b0});
        step("ld0w",   1'b0, 32'h100,      32'h0,        5'd6,  1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, '{32'hDEADBEEF, 5'd6, 1'b1, 1'b0});
        step("ld3w_a", 1'b0, 32'h104,      32'h0,        5'd7,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h11112222, 1'b1, 1'b1, BUBBLE);
        step("ld3w_b", 1'b0, 32'h104,      32'h0,        5'd7,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h11112222, 1'b1, 1'b1, BUBBLE);
        step("ld3w_c", 1'b0, 32'h104,      32'h0,        5'd7,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h11112222, 1'b1, 1'b1, BUBBLE);
        step("ld3w_d", 1'b0, 32'h104,      32'h0,        5'd7,  1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h11112222, 1'b1, 1'b0, '{32'h11112222, 5'd7, 1'b1, 1'b0});
        step("st1w_a", 1'b0, 32'h200,      32'hA5A5A5A5, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, BUBBLE);
        step("st1w_b", 1'b0, 32'h200,      32'hA5A5A5A5, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0,        1'b1, 1'b0, '{32'h200, 5'd0, 1'b0, 1'b0});
        step("stprio", 1'b0, 32'h300,      32'h1,        5'd9,  1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'hBAD,      1'b1, 1'b0, '{32'h300, 5'd9, 1'b0, 1'b0});
        step("to_req", 1'b0, 32'h400,      32'h0,        5'd8,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, BUBBLE);
        step("to_c1",  1'b0, 32'h400,      32'h0,        5'd8,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, BUBBLE);
        step("to_c2",  1'b0, 32'h400,      32'h0,        5'd8,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, BUBBLE);
        step("to_c3",  1'b0, 32'h400,      32'h0,        5'd8,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, BUBBLE);
        step("to_abt", 1'b0, 32'h400,      32'h0,        5'd8,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, '{32'h400, 5'd8, 1'b0, 1'b1});
        step("to_aft", 1'b0, 32'h0,        32'h0,        5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, BUBBLE);
        step("misal",  1'b0, 32'h102,      32'h0,        5'd10, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h77,       1'b0, 1'b0, '{32'h102, 5'd10, 1'b0, 1'b1});
        step("rb_req", 1'b0, 32'h500,      32'h0,        5'd11, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, BUBBLE);
        step("rb_rst", 1'b1, 32'h500,      32'h0,        5'd11, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, BUBBLE);
        step("rb_idl", 1'b0, 32'h0,        32'h0,        5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, BUBBLE);
        step("rb_ldA", 1'b0, 32'h600,      32'h0,        5'd12, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'hCAFEF00D, 1'b1, 1'b1, BUBBLE);
        step("rb_ldB", 1'b0, 32'h600,      32'h0,        5'd12, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'hCAFEF00D, 1'b1, 1'b1, BUBBLE);
        step("rb_ldC", 1'b0, 32'h600,      32'h0,        5'd12, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'hCAFEF00D, 1'b1, 1'b0, '{32'hCAFEF00D, 5'd12, 1'b1, 1'b0});
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
